// File: rtl/nes_loader_pkg.sv
// Shared definitions for the NES ROM loader.
// Contents:
//   state_t          loader FSM states
//   ERR_*            rejection codes reported on error_code
//   FLG_*            bit positions inside mapper_flags
//   PRG_PAGE/CHR_PAGE/TRN_BYTES  section granularities in bytes
//   size_bucket()    ceil-log2 bucket of a page count, saturating at 7
package nes_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_TRN  = 3'd1,
    S_PRG  = 3'd2,
    S_CHR  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_MAGIC   = 3'd1;
  localparam logic [2:0] ERR_EXPSIZE = 3'd2;
  localparam logic [2:0] ERR_PRG_OVF = 3'd3;
  localparam logic [2:0] ERR_CHR_OVF = 3'd4;
  localparam logic [2:0] ERR_NO_PRG  = 3'd5;

  // mapper_flags layout; bits [16:0] match the legacy iNES-only layout.
  localparam int FLG_MAPPER_LO   = 0;   // 8 bits
  localparam int FLG_PRG_SIZE    = 8;   // 3 bits
  localparam int FLG_CHR_SIZE    = 11;  // 3 bits
  localparam int FLG_MIRROR      = 14;
  localparam int FLG_CHR_RAM     = 15;
  localparam int FLG_FOUR_SCREEN = 16;
  localparam int FLG_TRAINER     = 17;
  localparam int FLG_BATTERY     = 18;
  localparam int FLG_NES20       = 19;
  localparam int FLG_MAPPER_HI   = 20;  // 4 bits
  localparam int FLG_SUBMAPPER   = 24;  // 4 bits

  localparam int PRG_PAGE  = 16384;
  localparam int CHR_PAGE  = 8192;
  localparam int TRN_BYTES = 512;

  function automatic logic [2:0] size_bucket(input logic [11:0] pages);
    logic [2:0] b;
    if      (pages <= 12'd1)  b = 3'd0;
    else if (pages <= 12'd2)  b = 3'd1;
    else if (pages <= 12'd4)  b = 3'd2;
    else if (pages <= 12'd8)  b = 3'd3;
    else if (pages <= 12'd16) b = 3'd4;
    else if (pages <= 12'd32) b = 3'd5;
    else if (pages <= 12'd64) b = 3'd6;
    else                      b = 3'd7;
    return b;
  endfunction

endpackage

// File: rtl/nes_rom_loader_if.sv
// Byte-stream input and cartridge-RAM write bus of the ROM loader.
// Signals:
//   in_data/in_valid/in_ready        image byte stream (source -> loader)
//   mem_addr/mem_data/mem_write      registered write port (loader -> arbiter)
//   mem_busy                         arbiter back-pressure (arbiter -> loader)
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready
// are both high; in_data must be stable while in_valid is high. mem_write is a
// single-cycle strobe that is never withdrawn once issued; mem_busy high means
// the arbiter cannot take a write in the next cycle, so the loader drops
// in_ready in its data states.
// Modports: slave = loader side, master = source/arbiter side.
interface nes_rom_loader_if #(
  parameter int ADDR_W = 22
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_write;
  logic              mem_busy;

  modport slave (
    input  in_data, in_valid, mem_busy,
    output in_ready, mem_addr, mem_data, mem_write
  );

  modport master (
    output in_data, in_valid, mem_busy,
    input  in_ready, mem_addr, mem_data, mem_write
  );
endinterface

// File: rtl/ines_header_decode.sv
// Combinational decode of a 16-byte iNES 1.0 / NES 2.0 header.
// Ports:
//   i_hdr        16 header bytes, i_hdr[0] is the first byte of the file
//   o_flags      mapper_flags word
//   o_prg_bytes  PRG section length in bytes
//   o_chr_bytes  CHR section length in bytes (0 means CHR RAM)
//   o_trainer    a 512-byte trainer precedes PRG
//   o_err_code   rejection reason, ERR_NONE when the header is accepted
module ines_header_decode
  import nes_loader_pkg::*;
#(
  parameter int PRG_MAX_LOG2 = 21,
  parameter int CHR_MAX_LOG2 = 20
) (
  input  logic [15:0][7:0] i_hdr,
  output logic [31:0]      o_flags,
  output logic [25:0]      o_prg_bytes,
  output logic [25:0]      o_chr_bytes,
  output logic             o_trainer,
  output logic [2:0]       o_err_code
);

  localparam logic [25:0] PRG_LIMIT = 26'd1 << PRG_MAX_LOG2;
  localparam logic [25:0] CHR_LIMIT = 26'd1 << CHR_MAX_LOG2;

  logic        w_nes20;
  logic        w_dirty;
  logic        w_magic_ok;
  logic [11:0] w_prg_pages;
  logic [11:0] w_chr_pages;
  logic [11:0] w_mapper;
  logic [3:0]  w_submapper;
  logic        w_unused_bits;

  // Header byte 7 bits [1:0] (console type) are not used by this loader.
  assign w_unused_bits = ^i_hdr[7][1:0];

  always_comb begin
    w_magic_ok = (i_hdr[0] == 8'h4E) && (i_hdr[1] == 8'h45) &&
                 (i_hdr[2] == 8'h53) && (i_hdr[3] == 8'h1A);
    w_nes20    = (i_hdr[7][3:2] == 2'b10);
    // Old dumpers left junk in bytes 8-15; such headers get only a 4-bit mapper.
    w_dirty    = !w_nes20 && (|{i_hdr[15], i_hdr[14], i_hdr[13], i_hdr[12],
                                i_hdr[11], i_hdr[10], i_hdr[9],  i_hdr[8]});

    w_prg_pages = w_nes20 ? {i_hdr[9][3:0], i_hdr[4]} : {4'b0, i_hdr[4]};
    w_chr_pages = w_nes20 ? {i_hdr[9][7:4], i_hdr[5]} : {4'b0, i_hdr[5]};

    if (w_nes20)      w_mapper = {i_hdr[8][3:0], i_hdr[7][7:4], i_hdr[6][7:4]};
    else if (w_dirty) w_mapper = {8'h00, i_hdr[6][7:4]};
    else              w_mapper = {4'h0, i_hdr[7][7:4], i_hdr[6][7:4]};
    w_submapper = w_nes20 ? i_hdr[8][7:4] : 4'h0;

    o_prg_bytes = 26'(w_prg_pages) * 26'(PRG_PAGE);
    o_chr_bytes = 26'(w_chr_pages) * 26'(CHR_PAGE);
    o_trainer   = i_hdr[6][2];

    // Ordered: the first failing check determines the code.
    if (!w_magic_ok)
      o_err_code = ERR_MAGIC;
    else if (w_nes20 && (i_hdr[9][3:0] == 4'hF || i_hdr[9][7:4] == 4'hF))
      o_err_code = ERR_EXPSIZE;
    else if (w_prg_pages == 12'd0)
      o_err_code = ERR_NO_PRG;
    else if (o_prg_bytes > PRG_LIMIT)
      o_err_code = ERR_PRG_OVF;
    else if (o_chr_bytes > CHR_LIMIT)
      o_err_code = ERR_CHR_OVF;
    else
      o_err_code = ERR_NONE;

    o_flags = '0;
    o_flags[FLG_MAPPER_LO +: 8] = w_mapper[7:0];
    o_flags[FLG_PRG_SIZE +: 3]  = size_bucket(w_prg_pages);
    o_flags[FLG_CHR_SIZE +: 3]  = size_bucket(w_chr_pages);
    o_flags[FLG_MIRROR]         = i_hdr[6][0];
    o_flags[FLG_CHR_RAM]        = (w_chr_pages == 12'd0);
    o_flags[FLG_FOUR_SCREEN]    = i_hdr[6][3];
    o_flags[FLG_TRAINER]        = i_hdr[6][2];
    o_flags[FLG_BATTERY]        = i_hdr[6][1];
    o_flags[FLG_NES20]          = w_nes20;
    o_flags[FLG_MAPPER_HI +: 4] = w_mapper[11:8];
    o_flags[FLG_SUBMAPPER +: 4] = w_submapper;
  end

endmodule

// File: rtl/nes_rom_loader.sv
// Streams an iNES / NES 2.0 image into cartridge RAM and publishes the
// decoded mapper flags.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   restart        synchronous pulse: abort and wait for a new header
//   bus            byte stream in, write port out (nes_rom_loader_if.slave)
//   mapper_flags   decoded header, valid from the cycle after the last header byte
//   done           image fully written (sticky until reset/restart)
//   error          image rejected (sticky until reset/restart)
//   error_code     rejection reason
//   dbg_state      current FSM state
module nes_rom_loader
  import nes_loader_pkg::*;
#(
  parameter int                ADDR_W       = 22,
  parameter logic [ADDR_W-1:0] PRG_BASE     = '0,
  parameter logic [ADDR_W-1:0] CHR_BASE     = ADDR_W'(22'h200000),
  parameter logic [ADDR_W-1:0] TRN_BASE     = ADDR_W'(22'h3FFE00),
  parameter int                PRG_MAX_LOG2 = 21,
  parameter int                CHR_MAX_LOG2 = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    restart,
  nes_rom_loader_if.slave         bus,
  output logic [31:0]             mapper_flags,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              error_code,
  output state_t                  dbg_state
);

  state_t            r_state;
  logic [3:0]        r_hdr_cnt;
  logic [14:0][7:0]  r_hdr;
  logic [25:0]       r_remain;
  logic [ADDR_W-1:0] r_ptr;
  logic [25:0]       r_prg_bytes;
  logic [25:0]       r_chr_bytes;
  logic [31:0]       r_flags;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_done;
  logic              r_error;
  logic [2:0]        r_error_code;

  logic              w_in_ready;
  logic              w_accept;
  logic [15:0][7:0]  w_hdr;
  logic [31:0]       w_dec_flags;
  logic [25:0]       w_dec_prg_bytes;
  logic [25:0]       w_dec_chr_bytes;
  logic              w_dec_trainer;
  logic [2:0]        w_dec_err;

  // The decoder sees the incoming byte as header byte 15 so the header can be
  // judged in the same cycle that byte is accepted.
  assign w_hdr = {bus.in_data, r_hdr};

  ines_header_decode #(
    .PRG_MAX_LOG2 (PRG_MAX_LOG2),
    .CHR_MAX_LOG2 (CHR_MAX_LOG2)
  ) u_decode (
    .i_hdr       (w_hdr),
    .o_flags     (w_dec_flags),
    .o_prg_bytes (w_dec_prg_bytes),
    .o_chr_bytes (w_dec_chr_bytes),
    .o_trainer   (w_dec_trainer),
    .o_err_code  (w_dec_err)
  );

  // Header and terminal states always drain; data states follow the arbiter.
  always_comb begin
    case (r_state)
      S_TRN, S_PRG, S_CHR: w_in_ready = !bus.mem_busy;
      default:             w_in_ready = 1'b1;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_HDR;
      r_hdr_cnt    <= '0;
      r_hdr        <= '0;
      r_remain     <= '0;
      r_ptr        <= '0;
      r_prg_bytes  <= '0;
      r_chr_bytes  <= '0;
      r_flags      <= '0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
    end else if (restart) begin
      // Overrides any byte accepted in this same cycle.
      r_state      <= S_HDR;
      r_hdr_cnt    <= '0;
      r_hdr        <= '0;
      r_remain     <= '0;
      r_ptr        <= '0;
      r_prg_bytes  <= '0;
      r_chr_bytes  <= '0;
      r_flags      <= '0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (w_accept) begin
            if (r_hdr_cnt == 4'd15) begin
              r_hdr_cnt   <= '0;
              r_flags     <= w_dec_flags;
              r_prg_bytes <= w_dec_prg_bytes;
              r_chr_bytes <= w_dec_chr_bytes;
              if (w_dec_err != ERR_NONE) begin
                r_state      <= S_ERR;
                r_error      <= 1'b1;
                r_error_code <= w_dec_err;
              end else if (w_dec_trainer) begin
                r_state  <= S_TRN;
                r_remain <= 26'(TRN_BYTES);
                r_ptr    <= TRN_BASE;
              end else begin
                r_state  <= S_PRG;
                r_remain <= w_dec_prg_bytes;
                r_ptr    <= PRG_BASE;
              end
            end else begin
              r_hdr[r_hdr_cnt] <= bus.in_data;
              r_hdr_cnt        <= r_hdr_cnt + 4'd1;
            end
          end
        end

        S_TRN, S_PRG, S_CHR: begin
          if (w_accept) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_data  <= bus.in_data;
            if (r_remain == 26'd1) begin
              // Last byte of the section: move on in the same cycle.
              case (r_state)
                S_TRN: begin
                  r_state  <= S_PRG;
                  r_remain <= r_prg_bytes;
                  r_ptr    <= PRG_BASE;
                end
                S_PRG: begin
                  if (r_chr_bytes != 26'd0) begin
                    r_state  <= S_CHR;
                    r_remain <= r_chr_bytes;
                    r_ptr    <= CHR_BASE;
                  end else begin
                    r_state  <= S_DONE;
                    r_remain <= '0;
                  end
                end
                default: begin
                  r_state  <= S_DONE;
                  r_remain <= '0;
                end
              endcase
            end else begin
              r_ptr    <= r_ptr + ADDR_W'(1);
              r_remain <= r_remain - 26'd1;
            end
          end
        end

        // Entered together with the final strobe, so done follows it by one cycle.
        S_DONE: r_done <= 1'b1;

        S_ERR: ;

        default: r_state <= S_HDR;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign mapper_flags  = r_flags;
  assign done          = r_done;
  assign error         = r_error;
  assign error_code    = r_error_code;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_nes_rom_loader.sv
// Bench for nes_rom_loader: directed header vectors, image bytes scored
// through an expected-write queue popped by an independent write monitor.
module tb_nes_rom_loader;
  import nes_loader_pkg::*;

  typedef logic [15:0][7:0] hdr_t;

  logic        clk;
  logic        reset_n;
  logic        restart;
  logic [31:0] mapper_flags;
  logic        done;
  logic        error;
  logic [2:0]  error_code;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [29:0] exp_q[$];

  nes_rom_loader_if #(.ADDR_W(22)) bus ();

  nes_rom_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .restart      (restart),
    .bus          (bus),
    .mapper_flags (mapper_flags),
    .done         (done),
    .error        (error),
    .error_code   (error_code),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic hdr_t make_hdr(input logic [7:0] h4, input logic [7:0] h5,
                                    input logic [7:0] h6, input logic [7:0] h7,
                                    input logic [7:0] h8, input logic [7:0] h9,
                                    input logic [7:0] h15);
    hdr_t h;
    h     = '0;
    h[0]  = 8'h4E;
    h[1]  = 8'h45;
    h[2]  = 8'h53;
    h[3]  = 8'h1A;
    h[4]  = h4;
    h[5]  = h5;
    h[6]  = h6;
    h[7]  = h7;
    h[8]  = h8;
    h[9]  = h9;
    h[15] = h15;
    return h;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready) begin
      waited++;
      if (waited >= 1000) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready stuck at %0b, required 1", bus.in_ready);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_data(input logic [21:0] addr, input logic [7:0] b);
    exp_q.push_back({addr, b});
    send_byte(b);
  endtask

  task automatic send_header(input hdr_t h);
    for (int i = 0; i < 16; i++) send_byte(h[i]);
  endtask

  task automatic send_section(input logic [21:0] base, input int n,
                              input bit gaps, input int busy_at);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (gaps && $urandom_range(0, 7) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if (i == busy_at) begin
        // Arbiter busy for three cycles with a byte waiting.
        bus.mem_busy = 1'b1;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("busy_stall_ready", 32'(bus.in_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        bus.mem_busy = 1'b0;
      end
      send_data(22'(base + 22'(i)), b);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_data"},  32'(bus.mem_data),  32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
    check({tag, "_error"},     32'(error),         32'd0);
    check({tag, "_error_code"},32'(error_code),    32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_state"},     32'(dbg_state),     32'(S_HDR));
  endtask

  task automatic check_done_timing(input string tag);
    @(negedge clk);
    check({tag, "_done_with_last_strobe"}, 32'(done), 32'd0);
    check({tag, "_last_strobe"}, 32'(bus.mem_write), 32'd1);
    @(negedge clk);
    check({tag, "_done_after"}, 32'(done), 32'd1);
    check({tag, "_state_done"}, 32'(dbg_state), 32'(S_DONE));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [29:0] e;
    if (reset_n && bus.mem_write) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_data} !== e) begin
          bad++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                   bus.mem_addr, bus.mem_data, e[29:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    hdr_t       h;
    logic [2:0] code;
  } err_vec_t;

  err_vec_t err_vecs[5];

  initial begin
    hdr_t h;

    reset_n      = 1'b0;
    restart      = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.mem_busy = 1'b0;

    repeat (3) @(negedge clk);
    check_idle("reset");
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Legacy image interrupted by reset mid-PRG.
    h = make_hdr(8'd2, 8'd1, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
    send_header(h);
    @(negedge clk);
    check("legacy_flags", mapper_flags, 32'h0000_0101);
    check("legacy_state", 32'(dbg_state), 32'(S_PRG));
    @(posedge clk);
    #1;
    send_section(22'h000000, 100, 1'b0, -1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_idle("midprg_reset");
    check("midprg_reset_queue", 32'(exp_q.size()), 32'd0);
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh full legacy image.
    send_header(h);
    @(negedge clk);
    check("legacy2_flags", mapper_flags, 32'h0000_0101);
    @(posedge clk);
    #1;
    send_section(22'h000000, 32768, 1'b0, -1);
    send_section(22'h200000, 8192, 1'b0, -1);
    check_done_timing("legacy");
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_byte(8'hA5);
    @(negedge clk);
    check("legacy_done_sticky", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    pulse_restart();

    // Trainer + CHR RAM, random gaps and a 3-cycle busy stall mid-PRG.
    h = make_hdr(8'd1, 8'd0, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
    send_header(h);
    @(negedge clk);
    check("trainer_flags", mapper_flags, 32'h0002_8000);
    check("trainer_state", 32'(dbg_state), 32'(S_TRN));
    @(posedge clk);
    #1;
    send_section(22'h3FFE00, 512, 1'b1, -1);
    send_section(22'h000000, 16384, 1'b1, 1000);
    check_done_timing("trainer");
    @(posedge clk);
    #1;
    pulse_restart();

    // NES 2.0 header, then restart together with an accepted PRG byte.
    h = make_hdr(8'd1, 8'd1, 8'h40, 8'h08, 8'h21, 8'h00, 8'h00);
    send_header(h);
    @(negedge clk);
    check("nes20_flags", mapper_flags, 32'h0218_0004);
    check("nes20_state", 32'(dbg_state), 32'(S_PRG));
    @(posedge clk);
    #1;
    send_section(22'h000000, 3, 1'b0, -1);
    restart = 1'b1;
    send_byte(8'h77);
    restart = 1'b0;
    #1;
    check_idle("restart_with_byte");

    // Non-2.0 header with junk in bytes 8-15: mapper high nibble dropped.
    h = make_hdr(8'd1, 8'd1, 8'h50, 8'h30, 8'h00, 8'h00, 8'h01);
    send_header(h);
    @(negedge clk);
    check("dirty_flags", mapper_flags, 32'h0000_0005);
    @(posedge clk);
    #1;
    pulse_restart();

    // Rejected headers: sticky error, no writes, trailing bytes drained even
    // with the arbiter busy.
    err_vecs[0].h = make_hdr(8'd1, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    err_vecs[0].h[3] = 8'h1B;
    err_vecs[0].code = ERR_MAGIC;
    err_vecs[1].h = make_hdr(8'd1, 8'd0, 8'h00, 8'h08, 8'h00, 8'h0F, 8'h00);
    err_vecs[1].code = ERR_EXPSIZE;
    err_vecs[2].h = make_hdr(8'd0, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    err_vecs[2].code = ERR_NO_PRG;
    err_vecs[3].h = make_hdr(8'h81, 8'd0, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00);
    err_vecs[3].code = ERR_PRG_OVF;
    err_vecs[4].h = make_hdr(8'd1, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    err_vecs[4].code = ERR_CHR_OVF;

    for (int v = 0; v < 5; v++) begin
      send_header(err_vecs[v].h);
      @(negedge clk);
      check($sformatf("err%0d_error", v), 32'(error), 32'd1);
      check($sformatf("err%0d_code", v), 32'(error_code), 32'(err_vecs[v].code));
      check($sformatf("err%0d_state", v), 32'(dbg_state), 32'(S_ERR));
      @(posedge clk);
      #1;
      bus.mem_busy = 1'b1;
      for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)));
      bus.mem_busy = 1'b0;
      @(negedge clk);
      check($sformatf("err%0d_sticky", v), 32'(error), 32'd1);
      check($sformatf("err%0d_in_ready", v), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      pulse_restart();
    end

    repeat (2) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
